// File: rtl/mem_fb_tracker_if.sv
// Bus bundle between the operand collector / memory unit feedback and mem_fb_tracker.
// master = environment side, slave = tracker side.
interface mem_fb_tracker_if #(
   parameter int NUM_WARPS = 8,
   parameter int NUM_SCB   = 4,
   parameter int MASK_W    = 8
);
   localparam int WID_W = $clog2(NUM_WARPS);
   localparam int SID_W = $clog2(NUM_SCB);

   logic                 issue_valid_i;
   logic [WID_W-1:0]     issue_warpID_i;
   logic [SID_W-1:0]     issue_scbID_i;
   logic [MASK_W-1:0]    issue_mask_i;

   logic                 neg_fb_valid_i;
   logic [WID_W-1:0]     neg_fb_warpID_i;
   logic [SID_W-1:0]     neg_fb_scbID_i;

   logic                 pos_fb_valid_i;
   logic [WID_W-1:0]     pos_fb_warpID_i;
   logic [SID_W-1:0]     pos_fb_scbID_i;
   logic [MASK_W-1:0]    pos_fb_mask_i;

   logic                 replay_valid_o;
   logic [WID_W-1:0]     replay_warpID_o;
   logic [SID_W-1:0]     replay_scbID_o;
   logic                 replay_ready_i;

   logic                 release_valid_o;
   logic [WID_W-1:0]     release_warpID_o;
   logic [SID_W-1:0]     release_scbID_o;

   logic [NUM_WARPS-1:0] warp_busy_o;
   logic                 err_o;
   logic                 timeout_o;

   modport master (
      output issue_valid_i, issue_warpID_i, issue_scbID_i, issue_mask_i,
      output neg_fb_valid_i, neg_fb_warpID_i, neg_fb_scbID_i,
      output pos_fb_valid_i, pos_fb_warpID_i, pos_fb_scbID_i, pos_fb_mask_i,
      output replay_ready_i,
      input  replay_valid_o, replay_warpID_o, replay_scbID_o,
      input  release_valid_o, release_warpID_o, release_scbID_o,
      input  warp_busy_o, err_o, timeout_o
   );

   modport slave (
      input  issue_valid_i, issue_warpID_i, issue_scbID_i, issue_mask_i,
      input  neg_fb_valid_i, neg_fb_warpID_i, neg_fb_scbID_i,
      input  pos_fb_valid_i, pos_fb_warpID_i, pos_fb_scbID_i, pos_fb_mask_i,
      input  replay_ready_i,
      output replay_valid_o, replay_warpID_o, replay_scbID_o,
      output release_valid_o, release_warpID_o, release_scbID_o,
      output warp_busy_o, err_o, timeout_o
   );
endinterface

// File: rtl/mem_fb_tracker.sv
// Per-(warp, scb) tracker of in-flight memory instructions: miss replay, completion release.
// Optional watchdog on PEND entries is enabled with `define MEM_FB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no instruction outstanding for this (warp, scb)
// PEND   | issued, waiting for completion feedback
// MISS   | missed in cache, waiting for the replay path to accept it
module mem_fb_tracker #(
   parameter int NUM_WARPS      = 8,
   parameter int NUM_SCB        = 4,
   parameter int MASK_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic           clk,
   input  logic           rst,
   mem_fb_tracker_if.slave bus
);
   localparam int WID_W = $clog2(NUM_WARPS);
   localparam int SID_W = $clog2(NUM_SCB);
   localparam int N     = NUM_WARPS * NUM_SCB;
   localparam int IDX_W = $clog2(N);
   localparam int IW1   = IDX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_MISS = 2'd2
   } state_e;

   state_e            r_state    [N];
   logic [MASK_W-1:0] r_exp      [N];
   logic [MASK_W-1:0] r_rcv      [N];
   state_e            w_nx_state [N];
   logic [MASK_W-1:0] w_nx_exp   [N];
   logic [MASK_W-1:0] w_nx_rcv   [N];

   logic [IDX_W-1:0]  w_iss_idx, w_neg_idx, w_pos_idx;
   logic              w_iss_coll, w_neg_pos_hit;
   logic              w_iss_ok, w_neg_ok, w_pos_ok;
   logic [MASK_W-1:0] w_pos_new;
   logic              w_pos_done, w_pos_extra;
   logic              w_err_evt;
   logic              w_grant;

   logic              r_rep_valid;
   logic [IDX_W-1:0]  r_rep_idx;
   logic [WID_W-1:0]  r_rep_warp;
   logic [SID_W-1:0]  r_rep_scb;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic              w_found;
   logic [IDX_W-1:0]  w_sel;
   logic [IW1-1:0]    w_scan;

   logic              r_rel_valid;
   logic [WID_W-1:0]  r_rel_warp;
   logic [SID_W-1:0]  r_rel_scb;
   logic              r_err;
   logic [NUM_WARPS-1:0] w_busy;

   assign w_iss_idx = IDX_W'(bus.issue_warpID_i) * IDX_W'(NUM_SCB) + IDX_W'(bus.issue_scbID_i);
   assign w_neg_idx = IDX_W'(bus.neg_fb_warpID_i) * IDX_W'(NUM_SCB) + IDX_W'(bus.neg_fb_scbID_i);
   assign w_pos_idx = IDX_W'(bus.pos_fb_warpID_i) * IDX_W'(NUM_SCB) + IDX_W'(bus.pos_fb_scbID_i);

   // All events are judged against the pre-cycle state; same-entry collisions reject the issue
   assign w_iss_coll    = (bus.neg_fb_valid_i && (w_neg_idx == w_iss_idx)) ||
                          (bus.pos_fb_valid_i && (w_pos_idx == w_iss_idx));
   assign w_neg_pos_hit = bus.neg_fb_valid_i && bus.pos_fb_valid_i && (w_neg_idx == w_pos_idx);

   assign w_iss_ok = bus.issue_valid_i && (r_state[w_iss_idx] == S_IDLE) &&
                     (|bus.issue_mask_i) && !w_iss_coll;
   assign w_neg_ok = bus.neg_fb_valid_i && (r_state[w_neg_idx] == S_PEND);
   assign w_pos_ok = bus.pos_fb_valid_i && (r_state[w_pos_idx] == S_PEND) && !w_neg_pos_hit;

   assign w_pos_new   = r_rcv[w_pos_idx] | bus.pos_fb_mask_i;
   assign w_pos_done  = ((w_pos_new & r_exp[w_pos_idx]) == r_exp[w_pos_idx]);
   assign w_pos_extra = |(bus.pos_fb_mask_i & ~r_exp[w_pos_idx]);

   assign w_err_evt = (bus.issue_valid_i && !w_iss_ok) ||
                      (bus.neg_fb_valid_i && !w_neg_ok) ||
                      (bus.pos_fb_valid_i && !w_pos_ok) ||
                      (w_pos_ok && w_pos_extra);

   assign w_grant = r_rep_valid && bus.replay_ready_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            r_state[i] <= S_IDLE;
            r_exp[i]   <= '0;
            r_rcv[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            r_state[i] <= w_nx_state[i];
            r_exp[i]   <= w_nx_exp[i];
            r_rcv[i]   <= w_nx_rcv[i];
         end
      end
   end

   // Accepted events can never hit the same entry, so the order below does not matter
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_nx_state[i] = r_state[i];
         w_nx_exp[i]   = r_exp[i];
         w_nx_rcv[i]   = r_rcv[i];
      end
      if (w_iss_ok) begin
         w_nx_state[w_iss_idx] = S_PEND;
         w_nx_exp[w_iss_idx]   = bus.issue_mask_i;
         w_nx_rcv[w_iss_idx]   = '0;
      end
      if (w_neg_ok) begin
         w_nx_state[w_neg_idx] = S_MISS;
      end
      if (w_pos_ok) begin
         if (w_pos_done) begin
            w_nx_state[w_pos_idx] = S_IDLE;
            w_nx_exp[w_pos_idx]   = '0;
            w_nx_rcv[w_pos_idx]   = '0;
         end else begin
            w_nx_rcv[w_pos_idx]   = w_pos_new & r_exp[w_pos_idx];
         end
      end
      if (w_grant) begin
         w_nx_state[r_rep_idx] = S_PEND;
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_scan  = '0;
      for (int k = 0; k < N; k++) begin
         w_scan = {1'b0, r_rr_ptr} + IW1'(k);
         if (w_scan >= IW1'(N)) begin
            w_scan = w_scan - IW1'(N);
         end
         if (!w_found && (r_state[w_scan[IDX_W-1:0]] == S_MISS)) begin
            w_found = 1'b1;
            w_sel   = w_scan[IDX_W-1:0];
         end
      end
   end

   // Offer drops for a cycle after each handshake so the next search sees the updated state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rep_valid <= 1'b0;
         r_rep_idx   <= '0;
         r_rep_warp  <= '0;
         r_rep_scb   <= '0;
         r_rr_ptr    <= '0;
      end else if (r_rep_valid) begin
         if (bus.replay_ready_i) begin
            r_rep_valid <= 1'b0;
            r_rr_ptr    <= (r_rep_idx == IDX_W'(N - 1)) ? '0 : r_rep_idx + 1'b1;
         end
      end else if (w_found) begin
         r_rep_valid <= 1'b1;
         r_rep_idx   <= w_sel;
         r_rep_warp  <= WID_W'(32'(w_sel) / NUM_SCB);
         r_rep_scb   <= SID_W'(32'(w_sel) % NUM_SCB);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rel_valid <= 1'b0;
         r_rel_warp  <= '0;
         r_rel_scb   <= '0;
      end else begin
         r_rel_valid <= w_pos_ok && w_pos_done;
         if (w_pos_ok && w_pos_done) begin
            r_rel_warp <= bus.pos_fb_warpID_i;
            r_rel_scb  <= bus.pos_fb_scbID_i;
         end
      end
   end

`ifdef MEM_FB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_tmo_cnt [N];
   logic             r_timeout;
   logic             w_tmo_hit;

   always_comb begin
      w_tmo_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((r_state[i] == S_PEND) && (w_nx_state[i] == S_PEND) &&
             (r_tmo_cnt[i] == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            w_tmo_hit = 1'b1;
         end
      end
   end

   // Counter restarts on every entry into PEND, including a replay grant out of MISS
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            r_tmo_cnt[i] <= '0;
         end
         r_timeout <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if ((w_nx_state[i] != S_PEND) || (r_state[i] != S_PEND)) begin
               r_tmo_cnt[i] <= '0;
            end else if (r_tmo_cnt[i] != CNT_W'(TIMEOUT_CYCLES)) begin
               r_tmo_cnt[i] <= r_tmo_cnt[i] + 1'b1;
            end
         end
         r_timeout <= w_tmo_hit;
      end
   end

   assign bus.timeout_o = r_timeout;
`else
   logic w_tmo_hit;

   assign w_tmo_hit     = 1'b0;
   assign bus.timeout_o = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err | w_err_evt | w_tmo_hit;
      end
   end

   always_comb begin
      w_busy = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         for (int s = 0; s < NUM_SCB; s++) begin
            if (r_state[w * NUM_SCB + s] != S_IDLE) begin
               w_busy[w] = 1'b1;
            end
         end
      end
   end

   assign bus.replay_valid_o   = r_rep_valid;
   assign bus.replay_warpID_o  = r_rep_warp;
   assign bus.replay_scbID_o   = r_rep_scb;
   assign bus.release_valid_o  = r_rel_valid;
   assign bus.release_warpID_o = r_rel_warp;
   assign bus.release_scbID_o  = r_rel_scb;
   assign bus.warp_busy_o      = w_busy;
   assign bus.err_o            = r_err;
endmodule
